// File: rtl/conv_layer_sequencer.sv
// Layer-pass sequencer: clears the address generator, issues TOTAL_STEPS enables under
// backpressure, drains the MAC pipeline, then pulses done and flips the ping-pong bank.
// Optional stall-cycle performance counter is built when CONV_SEQ_PERF_CNT_EN is defined.
module conv_layer_sequencer #(
    parameter int TOTAL_STEPS = 1024,
    parameter int STEP_WIDTH  = 16,
    parameter int PIPE_LAT    = 3,
    parameter int CLR_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stall,
    output logic                  agen_rst,
    output logic                  agen_enable,
    output logic                  data_valid,
    output logic [STEP_WIDTH-1:0] step_count,
    output logic                  busy,
    output logic                  done,
    output logic                  bank_sel
`ifdef CONV_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int PHASE_MAX = (CLR_CYCLES > PIPE_LAT) ? CLR_CYCLES : PIPE_LAT;
    localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [PW-1:0]         CLR_LAST   = PW'(CLR_CYCLES - 1);
    localparam logic [PW-1:0]         DRAIN_LAST = PW'(PIPE_LAT - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_LAST  = STEP_WIDTH'(TOTAL_STEPS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t              state;
    state_t              next_state;
    logic [PW-1:0]       phase_cnt;
    logic [PIPE_LAT-1:0] valid_sr;
    logic                abort_hit;

    assign abort_hit   = abort && (state != IDLE);
    assign agen_enable = (state == RUN) && !stall && !abort_hit;
    assign data_valid  = valid_sr[PIPE_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   if (phase_cnt == CLR_LAST) next_state = RUN;
            RUN:     if (agen_enable && step_count == STEP_LAST) next_state = DRAIN;
            DRAIN:   if (phase_cnt == DRAIN_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_hit) next_state = IDLE;
    end

    // Shared phase counter times both the CLEAR hold and the DRAIN wait; restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (next_state != state) begin
            phase_cnt <= '0;
        end else if (state == CLEAR || state == DRAIN) begin
            phase_cnt <= phase_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agen_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bank_sel   <= 1'b0;
            step_count <= '0;
            valid_sr   <= '0;
        end else begin
            agen_rst <= (next_state == CLEAR);
            busy     <= (next_state == CLEAR) || (next_state == RUN) || (next_state == DRAIN);
            done     <= (next_state == DONE);
            if (next_state == DONE) begin
                bank_sel <= ~bank_sel;
            end
            if (state == IDLE && start) begin
                step_count <= '0;
            end else if (agen_enable) begin
                step_count <= step_count + STEP_WIDTH'(1);
            end
            // An aborted pass must not leak in-flight valids into the next one.
            if (abort_hit) begin
                valid_sr <= '0;
            end else begin
                for (int i = PIPE_LAT - 1; i > 0; i--) begin
                    valid_sr[i] <= valid_sr[i-1];
                end
                valid_sr[0] <= agen_enable;
            end
        end
    end

`ifdef CONV_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == RUN && stall && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomised self-checking bench for conv_layer_sequencer (TOTAL_STEPS=8, PIPE_LAT=3, CLR_CYCLES=2);
// expected traces come from a pass-level timeline model built from enable/stall/abort rules.
module tb_conv_layer_sequencer;

    localparam int TOTAL = 8;
    localparam int PL    = 3;
    localparam int CC    = 2;
    localparam int SW    = 16;
    localparam int NCYC  = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          stall;
    logic          agen_rst;
    logic          agen_enable;
    logic          data_valid;
    logic [SW-1:0] step_count;
    logic          busy;
    logic          done;
    logic          bank_sel;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    conv_layer_sequencer #(
        .TOTAL_STEPS(TOTAL),
        .STEP_WIDTH (SW),
        .PIPE_LAT   (PL),
        .CLR_CYCLES (CC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .agen_rst   (agen_rst),
        .agen_enable(agen_enable),
        .data_valid (data_valid),
        .step_count (step_count),
        .busy       (busy),
        .done       (done),
        .bank_sel   (bank_sel)
`ifdef CONV_SEQ_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit            stall_pat [NCYC];
    bit            start_pat [NCYC];
    logic [5:0]    exp_flags [NCYC];
    logic [5:0]    obs_flags [NCYC];
    logic [SW-1:0] exp_cnt   [NCYC];
    logic [SW-1:0] obs_cnt   [NCYC];
    logic          bank_base;
    logic          next_bank;
    logic [SW-1:0] prev_count;
    logic [SW-1:0] next_count;
    int            exp_done_cyc;
    int            exp_stalls;
    int            base_done_obs;

    task automatic clear_patterns();
        for (int c = 0; c < NCYC; c++) begin
            stall_pat[c] = 1'b0;
            start_pat[c] = 1'b0;
        end
        start_pat[0] = 1'b1;
    endtask

    // Cycle 0 carries the start pulse; flags are {agen_rst, agen_enable, data_valid, busy, done, bank_sel}.
    task automatic build_expected(input int abort_at);
        logic    en_c [NCYC];
        int      en_seen;
        int      last_en;
        int      end_busy;
        logic    rst_e, dv_e, busy_e, done_e, bank_e;
        logic [SW-1:0] cnt;
        en_seen = 0;
        last_en = -1;
        for (int c = 0; c < NCYC; c++) en_c[c] = 1'b0;
        for (int c = CC + 1; c < NCYC && en_seen < TOTAL; c++) begin
            if (!stall_pat[c] && (abort_at < 0 || c < abort_at)) begin
                en_c[c] = 1'b1;
                en_seen++;
                last_en = c;
            end
        end
        if (abort_at >= 0) begin
            end_busy     = abort_at;
            exp_done_cyc = -1;
        end else begin
            end_busy     = last_en + PL;
            exp_done_cyc = last_en + PL + 1;
        end
        exp_stalls = 0;
        for (int c = CC + 1; c <= last_en; c++) if (stall_pat[c]) exp_stalls++;
        cnt = prev_count;
        for (int c = 0; c < NCYC; c++) begin
            rst_e  = (c >= 1) && (c <= CC) && (c <= end_busy);
            dv_e   = (c >= PL) && en_c[(c >= PL) ? c - PL : 0] && (abort_at < 0 || c <= abort_at);
            busy_e = (c >= 1) && (c <= end_busy);
            done_e = (c == exp_done_cyc);
            bank_e = bank_base ^ ((exp_done_cyc >= 0) && (c >= exp_done_cyc));
            if (c == 1) cnt = '0;
            else if (c > 1 && en_c[c-1]) cnt = cnt + SW'(1);
            exp_cnt[c]   = cnt;
            exp_flags[c] = {rst_e, en_c[c], dv_e, busy_e, done_e, bank_e};
        end
        next_bank  = bank_base ^ (exp_done_cyc >= 0);
        next_count = cnt;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic drive_pass(input int abort_at, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start = start_pat[c];
            stall = stall_pat[c];
            abort = (c == abort_at);
            @(negedge clk);
            obs_flags[c] = {agen_rst, agen_enable, data_valid, busy, done, bank_sel};
            obs_cnt[c]   = step_count;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        bank_base  = next_bank;
        prev_count = next_count;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({agen_rst, agen_enable, data_valid, busy, done, bank_sel} !== 6'b0 || step_count !== '0) begin
            bad++;
            $display("[TB] FAIL reset_hold flags=%b count=%0d expected all zero", {agen_rst, agen_enable, data_valid, busy, done, bank_sel}, step_count);
        end
`ifdef CONV_SEQ_PERF_CNT_EN
        total++;
        if (stall_cycles !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_perf got=%0d exp=0", stall_cycles);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({agen_rst, agen_enable, data_valid, busy, done, bank_sel} !== 6'b0 || step_count !== '0) begin
            bad++;
            $display("[TB] FAIL reset_release flags=%b count=%0d expected all zero", {agen_rst, agen_enable, data_valid, busy, done, bank_sel}, step_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_baseline();
        int n_en;
        int n_done;
        clear_patterns();
        build_expected(-1);
        drive_pass(-1, NCYC);
        n_en = 0;
        n_done = 0;
        base_done_obs = -1;
        for (int c = 0; c < NCYC; c++) begin
            total++;
            if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                bad++;
                $display("[TB] FAIL baseline cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
            end
            n_en += obs_flags[c][4];
            n_done += obs_flags[c][1];
            if (obs_flags[c][1] && base_done_obs < 0) base_done_obs = c;
        end
        total++;
        if (n_en !== TOTAL || n_done !== 1 || step_count !== SW'(TOTAL) || bank_sel !== 1'b1) begin
            bad++;
            $display("[TB] FAIL baseline_summary enables=%0d dones=%0d count=%0d bank=%b exp %0d/1/%0d/1", n_en, n_done, step_count, bank_sel, TOTAL, TOTAL);
        end
    endtask

    task automatic test_stall_window();
        int done_obs;
        clear_patterns();
        for (int c = 5; c <= 7; c++) stall_pat[c] = 1'b1;
        build_expected(-1);
        drive_pass(-1, NCYC);
        done_obs = -1;
        for (int c = 0; c < NCYC; c++) begin
            total++;
            if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                bad++;
                $display("[TB] FAIL stall_window cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
            end
            if (obs_flags[c][1] && done_obs < 0) done_obs = c;
        end
        total++;
        if (done_obs !== base_done_obs + 3) begin
            bad++;
            $display("[TB] FAIL stall_done_delay got=%0d exp=%0d", done_obs, base_done_obs + 3);
        end
`ifdef CONV_SEQ_PERF_CNT_EN
        total++;
        if (stall_cycles !== 32'd3) begin
            bad++;
            $display("[TB] FAIL stall_perf got=%0d exp=3", stall_cycles);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int ncyc;
        for (int p = 0; p < 2; p++) begin
            clear_patterns();
            start_pat[5 + p] = 1'b1;
            build_expected(-1);
            ncyc = (p == 0) ? exp_done_cyc + 1 : NCYC;
            drive_pass(-1, ncyc);
            for (int c = 0; c < ncyc; c++) begin
                total++;
                if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                    bad++;
                    $display("[TB] FAIL back_to_back pass=%0d cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", p, c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int ab;
        for (int k = 0; k < 2; k++) begin
            clear_patterns();
            if (k == 0) begin
                ab = CC + 1 + 4;
            end else begin
                for (int c = 0; c < 24; c++) stall_pat[c] = ($urandom_range(0, 2) == 0);
                build_expected(-1);
                ab = $urandom_range(1, exp_done_cyc - 1);
            end
            build_expected(ab);
            drive_pass(ab, NCYC);
            for (int c = 0; c < NCYC; c++) begin
                total++;
                if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                    bad++;
                    $display("[TB] FAIL abort at=%0d cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", ab, c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
                end
            end
        end
    endtask

    task automatic test_reset_in_drain();
        clear_patterns();
        build_expected(-1);
        drive_pass(-1, exp_done_cyc - 2);
        for (int c = 0; c < exp_done_cyc - 2; c++) begin
            total++;
            if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                bad++;
                $display("[TB] FAIL pre_reset cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({agen_rst, agen_enable, data_valid, busy, done, bank_sel} !== 6'b0 || step_count !== '0) begin
            bad++;
            $display("[TB] FAIL reset_in_drain flags=%b count=%0d expected all zero", {agen_rst, agen_enable, data_valid, busy, done, bank_sel}, step_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bank_base  = 1'b0;
        prev_count = '0;
        clear_patterns();
        build_expected(-1);
        drive_pass(-1, NCYC);
        for (int c = 0; c < NCYC; c++) begin
            total++;
            if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                bad++;
                $display("[TB] FAIL post_reset_pass cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
            end
        end
    endtask

    task automatic test_final_stall();
        clear_patterns();
        for (int c = 10; c <= 14; c++) stall_pat[c] = 1'b1;
        build_expected(-1);
        drive_pass(-1, NCYC);
        for (int c = 0; c < NCYC; c++) begin
            total++;
            if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                bad++;
                $display("[TB] FAIL final_stall cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
            end
        end
        total++;
        if (obs_cnt[14] !== SW'(TOTAL - 1) || obs_flags[14][2] !== 1'b1 || obs_flags[14][4] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL final_stall_hold count=%0d busy=%b en=%b exp %0d/1/0", obs_cnt[14], obs_flags[14][2], obs_flags[14][4], TOTAL - 1);
        end
    endtask

    task automatic test_random();
        int ab;
        int ncyc;
        int k;
        int done_free;
        for (int it = 0; it < 16; it++) begin
            clear_patterns();
            for (int c = 0; c < 24; c++) stall_pat[c] = ($urandom_range(0, 2) == 0);
            build_expected(-1);
            done_free = exp_done_cyc;
            ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, done_free - 1);
            k = $urandom_range(1, (ab >= 0) ? ab : done_free);
            start_pat[k] = 1'b1;
            build_expected(ab);
            ncyc = (ab >= 0) ? NCYC : $urandom_range(done_free + 1, NCYC);
            drive_pass(ab, ncyc);
            for (int c = 0; c < ncyc; c++) begin
                total++;
                if (obs_flags[c] !== exp_flags[c] || obs_cnt[c] !== exp_cnt[c]) begin
                    bad++;
                    $display("[TB] FAIL random it=%0d abort=%0d cyc=%0d flags got=%b exp=%b count got=%0d exp=%0d", it, ab, c, obs_flags[c], exp_flags[c], obs_cnt[c], exp_cnt[c]);
                end
            end
`ifdef CONV_SEQ_PERF_CNT_EN
            if (ab < 0) begin
                total++;
                if (stall_cycles !== 32'(exp_stalls)) begin
                    bad++;
                    $display("[TB] FAIL random_perf it=%0d got=%0d exp=%0d", it, stall_cycles, exp_stalls);
                end
            end
`endif
        end
    endtask

    initial begin
        bank_base     = 1'b0;
        prev_count    = '0;
        base_done_obs = -1;
        test_reset();
        test_baseline();
        test_stall_window();
        test_back_to_back();
        test_abort();
        test_reset_in_drain();
        test_final_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
